io_timer: RTL and testbench
===========================

Name: io_timer

Overview:
- Memory-mapped 16-bit timer/compare peripheral.
- Acts as the responder on the CPU data-memory/IO bus: decodes address, write-enable and read-enable, and returns read data.
- Drives one interrupt request line and accepts the matching interrupt-clear pulse.
- Sits in the IO page (0x10xx) alongside other IO peripherals. Read data is ORed into the CPU's data-in path by the SoC.

Parameters:
- BASE_ADDR, 16'h1000: address of register 0; block claims BASE_ADDR..BASE_ADDR+5.
- PRESCALE_W, 8: prescaler counter width; maximum division is 2^7.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-low
- address  input  16  bus address from CPU
- din  input  8  write data from CPU
- write_en  input  1  bus write strobe, one cycle
- read_en  input  1  bus read strobe, one cycle
- dout  output  8  registered read data; 0 when not selected
- interrupt  output  1  level interrupt request
- interrupt_clr  input  1  one-cycle acknowledge from CPU control
- out_pin  output  1  compare-toggle output

Behaviour:
- Reset (async, reset=0): all registers 0; dout=0, interrupt=0, out_pin=0, prescaler=0, shadows=0.
- Hit = (address - BASE_ADDR) < 6. Writes/reads outside the range are ignored.
- Register map (offset):
  - 0 CTRL: [0] en, [1] irq_en, [2] clr_on_match, [5:3] psel, [6] toggle_en, [7] reserved (reads 0).
  - 1 STATUS: [0] match flag. Write 1 clears it; write 0 has no effect.
  - 2 CNT_L
  - 3 CNT_H
  - 4 CMP_L
  - 5 CMP_H
- Read latency is 1 cycle:
  - read_en & hit at edge N → dout valid after edge N, held until the next read_en.
  - read_en & !hit → dout <= 0.
- Atomic 16-bit read:
  - Reading CNT_L returns cnt[7:0] and latches cnt[15:8] into rd_shadow.
  - Reading CNT_H returns rd_shadow, not the live value.
- Atomic 16-bit write (CNT and CMP each):
  - Writing _H stores into wr_shadow only.
  - Writing _L commits {wr_shadow, din} to the full register in the same edge.
  - A single shared wr_shadow serves both CNT and CMP.
- Prescaler:
  - When en=1, counts 0..(2^psel - 1). tick = 1 on the cycle the count equals 2^psel - 1, and the count wraps to 0.
  - psel=0 gives tick every cycle.
  - en=0: prescaler held at 0, no ticks, cnt holds.
  - Any CTRL write resets the prescaler to 0.
- Counter step on tick:
  - If cnt == cmp: set flag; next cnt = clr_on_match ? 0 : cnt+1; toggle out_pin if toggle_en.
  - Otherwise cnt+1, with 16'hFFFF → 16'h0000 wrap. Wrap itself sets no flag.
- interrupt = flag & irq_en, registered (asserts 1 cycle after flag sets).
- Flag clear sources: interrupt_clr=1, or STATUS write with din[0]=1.
- Simultaneous events:
  - Match set and clear in the same cycle → set wins (flag=1).
  - CNT_L commit and tick in the same cycle → bus write wins, and the prescaler resets to 0.
  - CMP commit and tick in the same cycle → the compare uses the old cmp.
- write_en and read_en together at a hit: write performed; read returns the pre-write value.
- Reset asserted mid-operation clears everything immediately; no pending shadow survives.

Decomposition:
- Shared package io_timer_pkg:
  - register offsets: OFF_CTRL..OFF_CMP_H
  - CTRL bit indices: CTRL_EN, CTRL_IRQEN, CTRL_CLRM, CTRL_PSEL_LSB/MSB, CTRL_TOG
  - STATUS_MATCH bit
- One sub-module: io_timer_prescaler (en, psel, restart in; tick out).
- Bus decode, register file, counter and interrupt logic stay in the top module.

Test Plan:
- Reset:
  - stimulus: pulse reset low mid-count with cnt=0x1234.
  - response: cnt, dout, interrupt and out_pin all 0 asynchronously; a CNT_L read returns 0x00.
- Count with prescale:
  - stimulus: write CMP_H=0x00, CMP_L=0x05, CTRL=0x0F (en, irq, clr_on_match, psel=1).
  - response: tick every 2 cycles; flag and interrupt rise after the 6th tick (cnt==5); cnt returns to 0; repeats with period 12 cycles.
- Atomic read:
  - stimulus: cnt runs at psel=0 from 0x00FE; read CNT_L, then CNT_H 3 cycles later.
  - response: CNT_L=0xFE, CNT_H=0x00 (the shadow), even though live cnt=0x0101.
- Write/commit and wrap:
  - stimulus: write CNT_H=0xFF; read CNT_L (still old); write CNT_L=0xFF; en with psel=0, cmp=0x8000.
  - response: cnt commits 0xFFFF only on the CNT_L write, wraps to 0x0000, no flag.
- Interrupt handshake:
  - stimulus: interrupt_clr pulsed on the same cycle as a new match.
  - response: flag stays 1.
  - stimulus: next interrupt_clr with no match.
  - response: flag=0 and interrupt=0 one cycle later.
  - stimulus: STATUS write 0x01.
  - response: also clears.
- Decode/toggle:
  - stimulus: read address 0x1006.
  - response: dout=0, no side effects.
  - stimulus: toggle_en=1 with 3 matches.
  - response: out_pin sequence 1,0,1.

Source files
------------

// File: rtl/io_timer_pkg.sv
// Shared register map and control-field layout for the io_timer peripheral.
package io_timer_pkg;

   localparam int NUM_REGS = 6;
   localparam int PSEL_W   = 3;

   typedef enum logic [2:0] {
      OFF_CTRL   = 3'd0,
      OFF_STATUS = 3'd1,
      OFF_CNT_L  = 3'd2,
      OFF_CNT_H  = 3'd3,
      OFF_CMP_L  = 3'd4,
      OFF_CMP_H  = 3'd5
   } regOffset_t;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQEN    = 1;
   localparam int CTRL_CLRM     = 2;
   localparam int CTRL_PSEL_LSB = 3;
   localparam int CTRL_PSEL_MSB = 5;
   localparam int CTRL_TOG      = 6;
   localparam int STATUS_MATCH  = 0;

   // Bit 7 of CTRL is reserved and never stored.
   localparam logic [7:0] CTRL_WMASK = 8'h7F;

   function automatic logic [PSEL_W-1:0] ctrlPsel(input logic [7:0] ctrl);
      return ctrl[CTRL_PSEL_MSB:CTRL_PSEL_LSB];
   endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// Power-of-two clock prescaler: one-cycle tick every 2^psel enabled cycles.
module io_timer_prescaler
   import io_timer_pkg::*;
#(
   parameter int PRESCALE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [PSEL_W-1:0] psel,
   input  logic              restart,
   output logic              tick
);

   logic [PRESCALE_W-1:0] countReg;
   logic [PRESCALE_W-1:0] terminal;

   assign terminal = (PRESCALE_W'(1) << psel) - PRESCALE_W'(1);
   assign tick     = en & (countReg == terminal);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         countReg <= '0;
      end else if (restart || !en || tick) begin
         countReg <= '0;
      end else begin
         countReg <= countReg + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped 16-bit timer/compare peripheral with atomic 16-bit access,
// match interrupt and compare-toggle output.
module io_timer
   import io_timer_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'h1000,
   parameter int          PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  din,
   input  logic        write_en,
   input  logic        read_en,
   output logic [7:0]  dout,
   output logic        interrupt,
   input  logic        interrupt_clr,
   output logic        out_pin
);

   logic [15:0] offset;
   logic        hit;
   logic [2:0]  regSel;
   logic        ctrlWr, statusWr, cntLWr, cmpLWr, shadowWr, cntLRd;

   logic [7:0]  ctrlReg, wrShadowReg, rdShadowReg, doutReg, rdData;
   logic [15:0] cntReg, cmpReg, cntNext;
   logic        flagReg, interruptReg, outPinReg;
   logic        tick, restart, cntEqCmp, matchEvent, flagClr;

   assign offset = address - BASE_ADDR;
   assign hit    = offset < 16'(NUM_REGS);
   assign regSel = offset[2:0];

   assign ctrlWr   = write_en & hit & (regSel == OFF_CTRL);
   assign statusWr = write_en & hit & (regSel == OFF_STATUS);
   assign cntLWr   = write_en & hit & (regSel == OFF_CNT_L);
   assign cmpLWr   = write_en & hit & (regSel == OFF_CMP_L);
   assign shadowWr = write_en & hit & ((regSel == OFF_CNT_H) | (regSel == OFF_CMP_H));
   assign cntLRd   = read_en & hit & (regSel == OFF_CNT_L);

   // A counter reload realigns the prescaler so the new value gets a full period.
   assign restart = ctrlWr | cntLWr;

   io_timer_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) prescaler (
      .clk    (clk),
      .reset  (reset),
      .en     (ctrlReg[CTRL_EN]),
      .psel   (ctrlPsel(ctrlReg)),
      .restart(restart),
      .tick   (tick)
   );

   // A CNT_L commit overrides the whole counter step, including its match.
   assign cntEqCmp   = (cntReg == cmpReg);
   assign matchEvent = tick & cntEqCmp & ~cntLWr;
   assign flagClr    = interrupt_clr | (statusWr & din[STATUS_MATCH]);

   always_comb begin
      cntNext = cntReg;
      if (cntLWr) begin
         cntNext = {wrShadowReg, din};
      end else if (tick) begin
         if (cntEqCmp && ctrlReg[CTRL_CLRM]) begin
            cntNext = 16'h0000;
         end else begin
            cntNext = cntReg + 16'd1;
         end
      end
   end

   always_comb begin
      rdData = 8'h00;
      case (regSel)
         OFF_CTRL:   rdData = ctrlReg;
         OFF_STATUS: rdData[STATUS_MATCH] = flagReg;
         OFF_CNT_L:  rdData = cntReg[7:0];
         OFF_CNT_H:  rdData = rdShadowReg;
         OFF_CMP_L:  rdData = cmpReg[7:0];
         OFF_CMP_H:  rdData = cmpReg[15:8];
         default:    rdData = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrlReg      <= 8'h00;
         wrShadowReg  <= 8'h00;
         rdShadowReg  <= 8'h00;
         cntReg       <= 16'h0000;
         cmpReg       <= 16'h0000;
         flagReg      <= 1'b0;
         interruptReg <= 1'b0;
         outPinReg    <= 1'b0;
         doutReg      <= 8'h00;
      end else begin
         if (ctrlWr)   ctrlReg     <= din & CTRL_WMASK;
         if (shadowWr) wrShadowReg <= din;
         if (cmpLWr)   cmpReg      <= {wrShadowReg, din};
         cntReg       <= cntNext;
         // Set beats clear when both land on the same edge.
         flagReg      <= matchEvent | (flagReg & ~flagClr);
         interruptReg <= flagReg & ctrlReg[CTRL_IRQEN];
         if (matchEvent && ctrlReg[CTRL_TOG]) outPinReg <= ~outPinReg;
         if (read_en)  doutReg     <= hit ? rdData : 8'h00;
         if (cntLRd)   rdShadowReg <= cntReg[15:8];
      end
   end

   assign dout      = doutReg;
   assign interrupt = interruptReg;
   assign out_pin   = outPinReg;

endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: directed scenarios plus random bus traffic
// checked every cycle against a cycle-level behavioural model.
module tb_io_timer;

   localparam logic [15:0] BASE = 16'h1000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] address = BASE;
   logic [7:0]  din = 8'h00;
   logic        write_en = 1'b0;
   logic        read_en = 1'b0;
   logic        interrupt_clr = 1'b0;
   logic [7:0]  dout;
   logic        interrupt;
   logic        out_pin;

   always #5 clk = ~clk;

   io_timer #(
      .BASE_ADDR (BASE),
      .PRESCALE_W(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .din          (din),
      .write_en     (write_en),
      .read_en      (read_en),
      .dout         (dout),
      .interrupt    (interrupt),
      .interrupt_clr(interrupt_clr),
      .out_pin      (out_pin)
   );

   typedef struct {
      bit          isRd;
      bit          isWr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          expDout;
      int          expIrq;
      int          expOut;
      bit          chkConstD;
      int          constD;
      bit          chkConstO;
      int          constO;
   } exp_t;

   exp_t expQ[$];
   int vectors = 0;
   int miscompares = 0;

   // Behavioural model state (plain integers)
   int mCtrl, mFlag, mCnt, mCmp, mWsh, mRsh, mPre, mIrq, mOut, mDout;

   task automatic check(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic modelReset();
      mCtrl = 0; mFlag = 0; mCnt = 0; mCmp = 0; mWsh = 0;
      mRsh = 0;  mPre = 0;  mIrq = 0; mOut = 0; mDout = 0;
   endtask

   function automatic bit matchNext();
      int psel;
      psel = (mCtrl >> 3) & 7;
      return ((mCtrl & 1) != 0) && (mPre == (1 << psel) - 1) && (mCnt == mCmp);
   endfunction

   task automatic modelStep(input logic [15:0] a, input bit wr, input bit rd,
                            input logic [7:0] d, input bit clr);
      logic [15:0] off;
      bit hit, en, tick, cntW, setF, clearF;
      int psel;
      off  = a - BASE;
      hit  = off < 16'd6;
      en   = (mCtrl & 1) != 0;
      psel = (mCtrl >> 3) & 7;
      tick = en && (mPre == (1 << psel) - 1);
      if (rd) begin
         if (!hit) mDout = 0;
         else case (off)
            0: mDout = mCtrl;
            1: mDout = mFlag;
            2: begin mDout = mCnt & 255; mRsh = mCnt >> 8; end
            3: mDout = mRsh;
            4: mDout = mCmp & 255;
            default: mDout = mCmp >> 8;
         endcase
      end
      mIrq = (mFlag != 0 && ((mCtrl >> 1) & 1) != 0) ? 1 : 0;
      cntW = wr && hit && off == 2;
      setF = 0;
      if (tick && !cntW) begin
         if (mCnt == mCmp) begin
            setF = 1;
            if (((mCtrl >> 6) & 1) != 0) mOut = mOut ^ 1;
            mCnt = (((mCtrl >> 2) & 1) != 0) ? 0 : (mCnt + 1) % 65536;
         end else begin
            mCnt = (mCnt + 1) % 65536;
         end
      end
      clearF = clr || (wr && hit && off == 1 && d[0]);
      if (setF) mFlag = 1;
      else if (clearF) mFlag = 0;
      if ((wr && hit && (off == 0 || off == 2)) || !en || tick) mPre = 0;
      else mPre = mPre + 1;
      if (wr && hit) begin
         case (off)
            0: mCtrl = d & 8'h7F;
            2: mCnt = mWsh * 256 + d;
            3: mWsh = d;
            4: mCmp = mWsh * 256 + d;
            5: mWsh = d;
            default: ;
         endcase
      end
   endtask

   task automatic doCycle(input logic [15:0] a, input bit wr, input bit rd,
                          input logic [7:0] d, input bit clr,
                          input bit cD, input int vD, input bit cO, input int vO);
      exp_t e;
      @(negedge clk);
      address = a; write_en = wr; read_en = rd; din = d; interrupt_clr = clr;
      if (!reset) modelReset();
      else modelStep(a, wr, rd, d, clr);
      e.isRd = rd; e.isWr = wr; e.addr = a; e.wdata = d;
      e.expDout = mDout; e.expIrq = mIrq; e.expOut = mOut;
      e.chkConstD = cD; e.constD = vD; e.chkConstO = cO; e.constO = vO;
      expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) doCycle(BASE, 0, 0, 8'h00, 0, 0, 0, 0, 0);
   endtask
   task automatic wr(input int o, input logic [7:0] d);
      doCycle(BASE + 16'(o), 1, 0, d, 0, 0, 0, 0, 0);
   endtask
   task automatic rd(input int o);
      doCycle(BASE + 16'(o), 0, 1, 8'h00, 0, 0, 0, 0, 0);
   endtask
   task automatic expectRd(input int o, input int v);
      doCycle(BASE + 16'(o), 0, 1, 8'h00, 0, 1, v, 0, 0);
   endtask
   task automatic clrPulse();
      doCycle(BASE, 0, 0, 8'h00, 1, 0, 0, 0, 0);
   endtask

   task automatic waitMatch(input string name);
      bit found;
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (matchNext()) found = 1;
         else idle(1);
      end
      if (!found) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic asyncReset();
      @(negedge clk);
      address = BASE; write_en = 0; read_en = 0; din = 0; interrupt_clr = 0;
      #2 reset = 1'b0;
      #1;
      check("async_rst_dout", dout, 0);
      check("async_rst_irq", interrupt, 0);
      check("async_rst_outpin", out_pin, 0);
      modelReset();
      idle(2);
      #1 reset = 1'b1;
   endtask

   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         check("dout", dout, e.expDout);
         check("interrupt", interrupt, e.expIrq);
         check("out_pin", out_pin, e.expOut);
         if (e.chkConstD) check("dout_const", dout, e.constD);
         if (e.chkConstO) check("out_pin_const", out_pin, e.constO);
         if (e.isRd || e.isWr)
            $display("%s%s addr=%h din=%h -> dout=%h irq=%0d out=%0d",
                     e.isWr ? "W" : "-", e.isRd ? "R" : "-", e.addr, e.wdata,
                     dout, interrupt, out_pin);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r, o;
      logic [7:0] d;
      logic [15:0] a;
      bit c;

      modelReset();
      idle(3);
      #1 reset = 1'b1;
      expectRd(2, 0);

      // Reset mid-count with cnt near 0x1234, flag, irq and out_pin active
      wr(5, 8'h12); wr(4, 8'h32); wr(3, 8'h12); wr(2, 8'h30);
      wr(0, 8'h43);
      idle(6);
      expectRd(0, 8'h43);
      asyncReset();
      expectRd(2, 0);

      // Count with prescale: psel=1, cmp=5, clear on match, irq
      wr(5, 8'h00); wr(4, 8'h05); wr(0, 8'h0F);
      idle(13);
      expectRd(1, 1);
      idle(24);
      wr(0, 8'h00); wr(1, 8'h01);

      // Atomic read
      wr(5, 8'h80); wr(4, 8'h00); wr(3, 8'h00); wr(2, 8'hFE);
      wr(0, 8'h01);
      expectRd(2, 8'hFE);
      idle(2);
      expectRd(3, 8'h00);
      wr(0, 8'h00);

      // Write/commit and wrap
      wr(1, 8'h01);
      wr(5, 8'h80); wr(4, 8'h00);
      wr(3, 8'hFF);
      rd(2);
      rd(3);
      wr(2, 8'hFF);
      wr(0, 8'h01);
      expectRd(2, 8'hFF);
      expectRd(2, 8'h00);
      expectRd(1, 0);
      wr(0, 8'h00);

      // Interrupt handshake
      wr(5, 8'h00); wr(4, 8'h03); wr(2, 8'h00); wr(0, 8'h07);
      waitMatch("hs1");
      clrPulse();
      expectRd(1, 1);
      clrPulse();
      expectRd(1, 0);
      waitMatch("hs2");
      idle(1);
      wr(1, 8'h00);
      expectRd(1, 1);
      waitMatch("hs3");
      idle(1);
      wr(1, 8'h01);
      expectRd(1, 0);
      wr(0, 8'h00); wr(1, 8'h01);

      // Decode outside the window
      doCycle(16'h1006, 0, 1, 8'h00, 0, 1, 0, 0, 0);
      doCycle(16'h1006, 1, 0, 8'hFF, 0, 0, 0, 0, 0);
      doCycle(16'h0FFF, 1, 0, 8'hFF, 0, 0, 0, 0, 0);
      doCycle(16'h0FFF, 0, 1, 8'h00, 0, 1, 0, 0, 0);
      expectRd(0, 0);

      // Toggle output: three matches give 1,0,1
      wr(5, 8'h00); wr(4, 8'h02); wr(2, 8'h00); wr(0, 8'h45);
      for (int k = 0; k < 3; k++) begin
         waitMatch("toggle");
         doCycle(BASE, 0, 0, 8'h00, 0, 0, 0, 1, (k % 2 == 0) ? 1 : 0);
      end
      wr(0, 8'h00);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         c = ($urandom_range(0, 7) == 0);
         o = $urandom_range(0, 6);
         if (o == 0) d = 8'($urandom) & 8'h4F;
         else if (o == 3 || o == 5) d = 8'h00;
         else d = 8'($urandom_range(0, 12));
         a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 7));
         if (r < 3) doCycle(BASE, 0, 0, 8'h00, c, 0, 0, 0, 0);
         else if (r < 6) doCycle(a, 0, 1, 8'h00, c, 0, 0, 0, 0);
         else if (r < 9) doCycle(BASE + 16'(o), 1, 0, d, c, 0, 0, 0, 0);
         else doCycle(BASE + 16'(o), 1, 1, d, c, 0, 0, 0, 0);
      end

      idle(2);
      repeat (4) @(negedge clk);
      check("queue_drain", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
